// File: rtl/mmio_button_io.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_button_io
//  Purpose  : Memory-mapped LED/HEX/KEY/SW peripheral with key debouncing,
//             sticky press events (W1C) and a maskable interrupt.
//  Revision : 1.0
// ============================================================================
module mmio_button_io #(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 10,
    parameter int NUM_LEDS        = 10,
    parameter int HEX_DIGITS      = 6,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int KEY_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sel,
    input  logic [31:0]             addr,
    input  logic [31:0]             writedata,
    input  logic                    memwrite,
    output logic [31:0]             readdata,
    input  logic [NUM_KEYS-1:0]     key_raw,
    input  logic [NUM_SW-1:0]       sw_raw,
    output logic [NUM_LEDS-1:0]     leds,
    output logic [4*HEX_DIGITS-1:0] hex_digits,
    output logic                    irq
);

    localparam int c_HEX_W = 4 * HEX_DIGITS;
    localparam int c_CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [c_CNT_W-1:0]  c_CNT_MAX  = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [NUM_KEYS-1:0] c_KEY_IDLE = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

    localparam logic [7:0] c_ADDR_LEDS   = 8'h04;
    localparam logic [7:0] c_ADDR_HEX    = 8'h08;
    localparam logic [7:0] c_ADDR_KEY    = 8'h10;
    localparam logic [7:0] c_ADDR_SW     = 8'h20;
    localparam logic [7:0] c_ADDR_EVENT  = 8'h40;
    localparam logic [7:0] c_ADDR_IRQ_EN = 8'h80;

    logic [NUM_KEYS-1:0] r_key_s1, r_key_s2;
    logic [NUM_SW-1:0]   r_sw_s1, r_sw_s2;
    logic [NUM_KEYS-1:0] r_stable;
    logic [c_CNT_W-1:0]  r_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] r_event;
    logic [NUM_KEYS-1:0] r_irq_en;
    logic [NUM_LEDS-1:0] r_leds;
    logic [c_HEX_W-1:0]  r_hex;
    logic                r_irq;

    logic                w_wr;
    logic [NUM_KEYS-1:0] w_key_sync;
    logic [NUM_KEYS-1:0] w_accept;
    logic [NUM_KEYS-1:0] w_rise;
    logic [NUM_KEYS-1:0] w_clr;
    logic                w_unused;

    assign w_unused = ^addr[31:8];

    // XOR with the idle level normalises polarity so pressed reads as 1.
    always_comb begin
        w_wr       = sel & memwrite;
        w_key_sync = r_key_s2 ^ c_KEY_IDLE;
        w_accept   = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            w_accept[i] = (w_key_sync[i] != r_stable[i]) && (r_cnt[i] == c_CNT_MAX);
        end
        w_rise = w_accept & w_key_sync;
        w_clr  = (w_wr && addr[7:0] == c_ADDR_EVENT) ? writedata[NUM_KEYS-1:0] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_s1 <= c_KEY_IDLE;
            r_key_s2 <= c_KEY_IDLE;
            r_sw_s1  <= '0;
            r_sw_s2  <= '0;
            r_stable <= '0;
            for (int i = 0; i < NUM_KEYS; i++) r_cnt[i] <= '0;
            r_event  <= '0;
            r_irq_en <= '0;
            r_leds   <= '0;
            r_hex    <= '0;
            r_irq    <= 1'b0;
        end else begin
            r_key_s1 <= key_raw;
            r_key_s2 <= r_key_s1;
            r_sw_s1  <= sw_raw;
            r_sw_s2  <= r_sw_s1;

            for (int i = 0; i < NUM_KEYS; i++) begin
                if (w_key_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_accept[i]) begin
                    r_stable[i] <= w_key_sync[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end
            end

            if (w_wr) begin
                case (addr[7:0])
                    c_ADDR_LEDS:   r_leds   <= writedata[NUM_LEDS-1:0];
                    c_ADDR_HEX:    r_hex    <= writedata[c_HEX_W-1:0];
                    c_ADDR_IRQ_EN: r_irq_en <= writedata[NUM_KEYS-1:0];
                    default: ;
                endcase
            end

            // A press landing in the same cycle as its clear must survive.
            r_event <= (r_event & ~w_clr) | w_rise;
            r_irq   <= |(r_event & r_irq_en);
        end
    end

    always_comb begin
        readdata = '0;
        if (sel) begin
            case (addr[7:0])
                c_ADDR_LEDS:   readdata = 32'(r_leds);
                c_ADDR_HEX:    readdata = 32'(r_hex);
                c_ADDR_KEY:    readdata = 32'(r_stable);
                c_ADDR_SW:     readdata = 32'(r_sw_s2);
                c_ADDR_EVENT:  readdata = 32'(r_event);
                c_ADDR_IRQ_EN: readdata = 32'(r_irq_en);
                default:       readdata = '0;
            endcase
        end
    end

    assign leds       = r_leds;
    assign hex_digits = r_hex;
    assign irq        = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_mmio_button_io.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_button_io
//  Purpose  : Scoreboard bench for mmio_button_io against a pin-history model.
//  Revision : 1.0
// ============================================================================
module tb_mmio_button_io;

    localparam int NK  = 4;
    localparam int NSW = 10;
    localparam int NL  = 10;
    localparam int HD  = 6;
    localparam int DB  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            sel;
    logic [31:0]     addr;
    logic [31:0]     writedata;
    logic            memwrite;
    logic [31:0]     readdata;
    logic [NK-1:0]   key_raw;
    logic [NSW-1:0]  sw_raw;
    logic [NL-1:0]   leds;
    logic [4*HD-1:0] hex_digits;
    logic            irq;

    mmio_button_io #(
        .NUM_KEYS(NK), .NUM_SW(NSW), .NUM_LEDS(NL), .HEX_DIGITS(HD),
        .DEBOUNCE_CYCLES(DB), .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .addr(addr), .writedata(writedata),
        .memwrite(memwrite), .readdata(readdata), .key_raw(key_raw), .sw_raw(sw_raw),
        .leds(leds), .hex_digits(hex_digits), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     rd;
        logic [NL-1:0]   leds;
        logic [4*HD-1:0] hex;
        logic            irq;
        logic [7:0]      a;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: register contents plus a per-key window of recent pin samples.
    logic [NL-1:0]   m_leds;
    logic [4*HD-1:0] m_hex;
    logic [NK-1:0]   m_event, m_irq_en, m_stable;
    logic            m_irq;
    logic [NSW-1:0]  m_sw_last, m_sw_prev;
    logic [DB+1:0]   m_win [NK];

    logic [NK-1:0]   cur_pressed;
    logic [NSW-1:0]  cur_sw;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read();
        if (!sel) return 32'h0;
        case (addr[7:0])
            8'h04:   return 32'(m_leds);
            8'h08:   return 32'(m_hex);
            8'h10:   return 32'(m_stable);
            8'h20:   return 32'(m_sw_prev);
            8'h40:   return 32'(m_event);
            8'h80:   return 32'(m_irq_en);
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_edge();
        logic [NK-1:0] clr, rise;
        logic          flip;
        if (reset) begin
            m_leds = '0; m_hex = '0; m_event = '0; m_irq_en = '0; m_irq = 1'b0;
            m_stable = '0; m_sw_last = '0; m_sw_prev = '0;
            for (int k = 0; k < NK; k++) m_win[k] = '0;
            return;
        end
        m_irq = |(m_event & m_irq_en);
        clr = '0;
        if (sel && memwrite) begin
            case (addr[7:0])
                8'h04: m_leds   = writedata[NL-1:0];
                8'h08: m_hex    = writedata[4*HD-1:0];
                8'h40: clr      = writedata[NK-1:0];
                8'h80: m_irq_en = writedata[NK-1:0];
                default: ;
            endcase
        end
        m_sw_prev = m_sw_last;
        m_sw_last = sw_raw;
        rise = '0;
        for (int k = 0; k < NK; k++) begin
            m_win[k] = {m_win[k][DB:0], ~key_raw[k]};
            // Bits 2..DB+1 are the synchronised samples seen over the last DB edges.
            flip = 1'b1;
            for (int j = 2; j <= DB + 1; j++) if (m_win[k][j] == m_stable[k]) flip = 1'b0;
            if (flip) begin
                m_stable[k] = ~m_stable[k];
                if (m_stable[k]) rise[k] = 1'b1;
            end
        end
        m_event = (m_event & ~clr) | rise;
    endtask

    task automatic step(input logic r, input logic s, input logic we,
                        input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        reset = r; sel = s; memwrite = we; addr = a; writedata = wd;
        key_raw = ~cur_pressed; sw_raw = cur_sw;
        e.rd = model_read(); e.leds = m_leds; e.hex = m_hex; e.irq = m_irq; e.a = a[7:0];
        sb.push_back(e);
        model_edge();
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, 1'b1, 1'b0, {24'h0, a}, 32'h0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 1'b1, {24'h0, a}, d);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("readdata[%0h]", e.a), readdata, e.rd);
                check("leds", 32'(leds), 32'(e.leds));
                check("hex_digits", 32'(hex_digits), 32'(e.hex));
                check("irq", 32'(irq), 32'(e.irq));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] a, d;
        logic [7:0]  picks [9];
        picks = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h0C, 8'h00, 8'h44};

        cur_pressed = '0; cur_sw = '0;
        reset = 1'b1; sel = 1'b0; memwrite = 1'b0; addr = '0; writedata = '0;
        key_raw = '1; sw_raw = '0;
        @(posedge clk);
        model_edge();

        // Reset state
        step(1'b1, 1'b1, 1'b0, 32'h04, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h08, 32'h0);
        foreach (picks[i]) rd(picks[i]);

        // Writable registers and switch sync
        cur_sw = 10'h2A5;
        wr(8'h04, 32'hFFFF_F3C1);
        rd(8'h04);
        wr(8'h08, 32'h00AB_CDEF);
        repeat (3) rd(8'h20);
        rd(8'h08);

        // Held press on key1, then a short glitch on key2
        cur_pressed = 4'b0010;
        repeat (8) rd(8'h10);
        rd(8'h40);
        cur_pressed = 4'b0110;
        repeat (DB - 1) rd(8'h10);
        cur_pressed = 4'b0010;
        repeat (8) rd(8'h10);
        rd(8'h40);

        // Interrupt mask, W1C and clear colliding with a new press
        wr(8'h80, 32'h2);
        repeat (2) rd(8'h40);
        wr(8'h40, 32'h2);
        repeat (2) rd(8'h40);
        cur_pressed = 4'b0000;
        repeat (8) rd(8'h10);
        cur_pressed = 4'b0010;
        repeat (5) rd(8'h10);
        wr(8'h40, 32'h2);
        repeat (3) rd(8'h40);
        wr(8'h40, 32'hF);
        cur_pressed = 4'b0000;
        repeat (8) rd(8'h10);

        // Reset during debounce of a held key0
        cur_pressed = 4'b0001;
        repeat (4) rd(8'h10);
        step(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        repeat (8) rd(8'h40);

        // Unselected store and unmapped read
        step(1'b0, 1'b0, 1'b1, 32'h04, 32'h0000_0155);
        rd(8'h04);
        rd(8'h0C);
        cur_pressed = 4'b0000;

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < NK; k++)
                if ($urandom_range(5) == 0) cur_pressed[k] = ~cur_pressed[k];
            if ($urandom_range(15) == 0) cur_sw = NSW'($urandom());
            a = $urandom();
            if ($urandom_range(3) != 0) a[31:8] = '0;
            a[7:0] = ($urandom_range(7) == 0) ? 8'($urandom()) : picks[$urandom_range(8)];
            d = $urandom();
            step(($urandom_range(299) == 0), ($urandom_range(7) != 0),
                 ($urandom_range(2) == 0), a, d);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
